// File: rtl/axil_slave_bridge.sv
// rtl/axil_slave_bridge.sv - AXI-Lite slave front end feeding an in-order backend request FIFO
module axil_slave_bridge #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int REQ_DEPTH  = 4
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic                    req_vld,
  input  logic                    req_rdy,
  output logic                    req_typ,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [DATA_WIDTH-1:0]   req_data,
  output logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic                    rsp_vld,
  input  logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [4:0]              req_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(REQ_DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
  localparam logic [4:0]           DEPTH_CNT = 5'(REQ_DEPTH);

  typedef enum logic {
    WR_WAIT_ADDR = 1'b0,
    WR_WAIT_DATA = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_WAIT_ADDR  = 2'd0,
    RD_WAIT_RSP   = 2'd1,
    RD_DRIVE_DATA = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic                  typ;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } req_entry_t;

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]            count_q, count_d;
  req_entry_t            fifo_q [REQ_DEPTH];

  logic       full;
  logic       empty;
  logic       wr_push;
  logic       rd_push;
  logic       push;
  logic       pop;
  req_entry_t push_entry;
  req_entry_t head;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == 5'd0);

  // Ready signals are gated by reset so nothing is advertised while the bridge is held in reset;
  // a write push owns the FIFO port in any cycle where it may complete.
  assign axi_awready = axi_aresetn && (wr_state_q == WR_WAIT_ADDR);
  assign axi_wready  = (wr_state_q == WR_WAIT_DATA) && !full;
  assign axi_arready = axi_aresetn && (rd_state_q == RD_WAIT_ADDR) && !full &&
                       !((wr_state_q == WR_WAIT_DATA) && axi_wvalid);
  assign axi_rvalid  = (rd_state_q == RD_DRIVE_DATA);
  assign axi_rdata   = rdata_q;

  assign wr_push = axi_wvalid && axi_wready;
  assign rd_push = axi_arvalid && axi_arready;
  assign push    = wr_push || rd_push;
  assign pop     = req_vld && req_rdy;

  assign req_count = count_q;
  assign head      = fifo_q[rd_ptr_q];

  // Select the entry being queued this cycle; reads carry zero data and strobes.
  always_comb begin
    push_entry = '0;
    if (wr_push) begin
      push_entry.typ  = 1'b0;
      push_entry.addr = awaddr_q;
      push_entry.data = axi_wdata;
      push_entry.strb = axi_wstrb;
    end else begin
      push_entry.typ  = 1'b1;
      push_entry.addr = axi_araddr;
    end
  end

  // Present the FIFO head to the backend, forced to zero when nothing is queued.
  always_comb begin
    req_vld  = 1'b0;
    req_typ  = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_strb = '0;
    if (!empty) begin
      req_vld  = 1'b1;
      req_typ  = head.typ;
      req_addr = head.addr;
      req_data = head.data;
      req_strb = head.strb;
    end
  end

  // Write channel next state: latch AW, then wait for the W beat that queues the request.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    case (wr_state_q)
      WR_WAIT_ADDR: begin
        if (axi_awvalid && axi_awready) begin
          wr_state_d = WR_WAIT_DATA;
          awaddr_d   = axi_awaddr;
        end
      end
      WR_WAIT_DATA: begin
        if (wr_push) begin
          wr_state_d = WR_WAIT_ADDR;
        end
      end
      default: wr_state_d = WR_WAIT_ADDR;
    endcase
  end

  // Read channel next state: one outstanding read, response captured and held until R handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_WAIT_ADDR: begin
        if (rd_push) begin
          rd_state_d = RD_WAIT_RSP;
        end
      end
      RD_WAIT_RSP: begin
        if (rsp_vld) begin
          rd_state_d = RD_DRIVE_DATA;
          rdata_d    = rsp_data;
        end
      end
      RD_DRIVE_DATA: begin
        if (axi_rready) begin
          rd_state_d = RD_WAIT_ADDR;
          rdata_d    = '0;
        end
      end
      default: begin
        rd_state_d = RD_WAIT_ADDR;
        rdata_d    = '0;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap explicitly at the last slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset aborts any transaction and discards every queued request.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_state_q <= WR_WAIT_ADDR;
      rd_state_q <= RD_WAIT_ADDR;
      awaddr_q   <= '0;
      rdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awaddr_q   <= awaddr_d;
      rdata_q    <= rdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage needs no reset: stale slots are never visible because outputs are gated by count.
  always_ff @(posedge axi_aclk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_axil_slave_bridge.sv
// tb/tb_axil_slave_bridge.sv - randomized scenario bench for axil_slave_bridge with a queue reference model
`timescale 1ns/1ps
module tb_axil_slave_bridge;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          axi_awvalid = 1'b0;
  logic          axi_awready;
  logic [AW-1:0] axi_awaddr = '0;
  logic          axi_wvalid = 1'b0;
  logic          axi_wready;
  logic [DW-1:0] axi_wdata = '0;
  logic [SW-1:0] axi_wstrb = '0;
  logic          axi_arvalid = 1'b0;
  logic          axi_arready;
  logic [AW-1:0] axi_araddr = '0;
  logic          axi_rvalid;
  logic          axi_rready = 1'b0;
  logic [DW-1:0] axi_rdata;
  logic          req_vld;
  logic          req_rdy = 1'b0;
  logic          req_typ;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [SW-1:0] req_strb;
  logic          rsp_vld = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic [4:0]    req_count;

  typedef struct packed {
    logic          typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } req_t;

  req_t          model_q[$];
  logic [DW-1:0] exp_rdata;
  int            errors = 0;
  int            checks = 0;

  axil_slave_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_DEPTH(DEPTH)) dut (
    .axi_aclk(clk), .axi_aresetn(rstn),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_typ(req_typ), .req_addr(req_addr),
    .req_data(req_data), .req_strb(req_strb),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .req_count(req_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drivers start and end 1ns after a rising edge; outputs are sampled 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [AW-1:0] a, output bit ok);
    axi_awvalid = 1'b1;
    axi_awaddr  = a;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = axi_awready;
      tick();
    end
    axi_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [DW-1:0] d, input logic [SW-1:0] s, output bit ok);
    axi_wvalid = 1'b1;
    axi_wdata  = d;
    axi_wstrb  = s;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = axi_wready;
      tick();
    end
    axi_wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          output bit ok);
    bit ok_a, ok_d;
    do_aw(a, ok_a);
    ok_d = 1'b0;
    if (ok_a) do_w(d, s, ok_d);
    ok = ok_a && ok_d;
    if (ok) model_q.push_back('{1'b0, a, d, s});
  endtask

  task automatic do_ar(input logic [AW-1:0] a, output bit ok);
    axi_arvalid = 1'b1;
    axi_araddr  = a;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = axi_arready;
      tick();
    end
    axi_arvalid = 1'b0;
    if (ok) model_q.push_back('{1'b1, a, '0, '0});
  endtask

  task automatic do_pop(output req_t got, output bit ok);
    req_rdy = 1'b1;
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (req_vld) begin
        got = '{req_typ, req_addr, req_data, req_strb};
        ok = 1'b1;
      end
      tick();
    end
    req_rdy = 1'b0;
  endtask

  task automatic do_rsp_read(input logic [DW-1:0] d, output logic [DW-1:0] got, output bit ok);
    rsp_vld  = 1'b1;
    rsp_data = d;
    tick();
    rsp_vld = 1'b0;
    axi_rready = 1'b1;
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (axi_rvalid) begin
        got = axi_rdata;
        ok = 1'b1;
      end
      tick();
    end
    axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (axi_awready !== 1'b0) begin errors++; $display("FAIL reset_awready got=%b exp=0", axi_awready); end
    checks++; if (axi_arready !== 1'b0) begin errors++; $display("FAIL reset_arready got=%b exp=0", axi_arready); end
    checks++; if ({axi_wready, axi_rvalid, req_vld} !== 3'b000) begin errors++; $display("FAIL reset_valids got=%b exp=000", {axi_wready, axi_rvalid, req_vld}); end
    checks++; if (req_count !== 5'd0 || axi_rdata !== '0) begin errors++; $display("FAIL reset_count_rdata count=%0d rdata=%h exp=0/0", req_count, axi_rdata); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    checks++; if (axi_awready !== 1'b1 || axi_arready !== 1'b1) begin errors++; $display("FAIL release_ready aw=%b ar=%b exp=1/1", axi_awready, axi_arready); end
    tick();
  endtask

  task automatic test_single_write();
    bit ok;
    req_t exp;
    req_rdy = 1'b1;
    do_write(AW'(16'h0100), 32'h12345678, 4'hF, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_write_handshake got=timeout exp=done"); end
    exp = '{1'b0, AW'(16'h0100), 32'h12345678, 4'hF};
    #1;
    checks++; if (req_vld !== 1'b1) begin errors++; $display("FAIL single_write_latency req_vld=%b exp=1", req_vld); end
    checks++; if ({req_typ, req_addr, req_data, req_strb} !== exp) begin errors++; $display("FAIL single_write_entry got=%h exp=%h", {req_typ, req_addr, req_data, req_strb}, exp); end
    if (model_q.size() != 0) void'(model_q.pop_front());
    tick();
    #1;
    checks++; if (req_vld !== 1'b0 || req_count !== 5'd0) begin errors++; $display("FAIL single_write_pulse req_vld=%b count=%0d exp=0/0", req_vld, req_count); end
    req_rdy = 1'b0;
    tick();
  endtask

  task automatic test_read();
    bit ok;
    req_t exp;
    do_ar(AW'(16'h0004), ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_ar_handshake got=timeout exp=done"); end
    req_rdy = 1'b1;
    exp = '{1'b1, AW'(16'h0004), '0, '0};
    #1;
    checks++; if ({req_vld, req_typ, req_addr, req_data, req_strb} !== {1'b1, exp}) begin errors++; $display("FAIL read_entry got=%h exp=%h", {req_vld, req_typ, req_addr, req_data, req_strb}, {1'b1, exp}); end
    checks++; if (axi_arready !== 1'b0) begin errors++; $display("FAIL read_outstanding_arready got=%b exp=0", axi_arready); end
    if (model_q.size() != 0) void'(model_q.pop_front());
    tick();
    req_rdy = 1'b0;
    tick();
    tick();
    rsp_vld = 1'b1;
    rsp_data = 32'hDEADBEEF;
    #1;
    checks++; if (axi_rvalid !== 1'b0) begin errors++; $display("FAIL read_early_rvalid got=%b exp=0", axi_rvalid); end
    tick();
    rsp_vld = 1'b0;
    rsp_data = $urandom;
    #1;
    checks++; if (axi_rvalid !== 1'b1 || axi_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rvalid rvalid=%b rdata=%h exp=1/deadbeef", axi_rvalid, axi_rdata); end
    for (int i = 0; i < 2; i++) begin
      tick();
      rsp_vld = (i == 0);
      rsp_data = 32'h0BADF00D;
      #1;
      checks++; if (axi_rvalid !== 1'b1 || axi_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_hold%0d rvalid=%b rdata=%h exp=1/deadbeef", i, axi_rvalid, axi_rdata); end
    end
    tick();
    rsp_vld = 1'b0;
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    #1;
    checks++; if (axi_rvalid !== 1'b0 || axi_rdata !== '0 || axi_arready !== 1'b1) begin errors++; $display("FAIL read_done rvalid=%b rdata=%h arready=%b exp=0/0/1", axi_rvalid, axi_rdata, axi_arready); end
    tick();
    rsp_vld = 1'b1;
    rsp_data = 32'hCAFEF00D;
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (axi_rvalid !== 1'b0 || axi_rdata !== '0) begin errors++; $display("FAIL stray_rsp rvalid=%b rdata=%h exp=0/0", axi_rvalid, axi_rdata); end
    tick();
  endtask

  task automatic test_full();
    bit ok;
    req_t got, exp;
    logic [AW-1:0] a5;
    logic [DW-1:0] d5;
    logic [SW-1:0] s5;
    req_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'($urandom), $urandom, SW'($urandom), ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_fill%0d got=timeout exp=done", i); end
    end
    #1;
    checks++; if (req_count !== 5'(DEPTH)) begin errors++; $display("FAIL full_count got=%0d exp=%0d", req_count, DEPTH); end
    tick();
    a5 = AW'($urandom);
    d5 = $urandom;
    s5 = SW'($urandom);
    do_aw(a5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_aw5 got=timeout exp=done"); end
    axi_wvalid = 1'b1;
    axi_wdata  = d5;
    axi_wstrb  = s5;
    #1;
    checks++; if (axi_wready !== 1'b0 || axi_arready !== 1'b0) begin errors++; $display("FAIL full_blocks wready=%b arready=%b exp=0/0", axi_wready, axi_arready); end
    tick();
    #1;
    checks++; if (axi_wready !== 1'b0) begin errors++; $display("FAIL full_wready_hold got=%b exp=0", axi_wready); end
    tick();
    req_rdy = 1'b1;
    #1;
    exp = (model_q.size() != 0) ? model_q.pop_front() : '0;
    checks++; if ({req_vld, req_typ, req_addr, req_data, req_strb} !== {1'b1, exp}) begin errors++; $display("FAIL full_head got=%h exp=%h", {req_vld, req_typ, req_addr, req_data, req_strb}, {1'b1, exp}); end
    tick();
    req_rdy = 1'b0;
    #1;
    checks++; if (axi_wready !== 1'b1 || req_count !== 5'd3) begin errors++; $display("FAIL full_slot_freed wready=%b count=%0d exp=1/3", axi_wready, req_count); end
    tick();
    axi_wvalid = 1'b0;
    model_q.push_back('{1'b0, a5, d5, s5});
    #1;
    checks++; if (req_count !== 5'd4) begin errors++; $display("FAIL full_refill got=%0d exp=4", req_count); end
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      do_pop(got, ok);
      exp = (model_q.size() != 0) ? model_q.pop_front() : '0;
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL full_drain%0d ok=%b got=%h exp=%h", i, ok, got, exp); end
    end
  endtask

  task automatic test_write_read_collision();
    bit ok;
    req_t got, exp;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rd_got, rd_exp;
    wa = AW'($urandom);
    ra = AW'($urandom);
    wd = $urandom;
    req_rdy = 1'b0;
    do_aw(wa, ok);
    checks++; if (!ok) begin errors++; $display("FAIL collide_aw got=timeout exp=done"); end
    axi_wvalid  = 1'b1;
    axi_wdata   = wd;
    axi_wstrb   = 4'h5;
    axi_arvalid = 1'b1;
    axi_araddr  = ra;
    #1;
    checks++; if (axi_wready !== 1'b1 || axi_arready !== 1'b0) begin errors++; $display("FAIL collide_priority wready=%b arready=%b exp=1/0", axi_wready, axi_arready); end
    tick();
    model_q.push_back('{1'b0, wa, wd, 4'h5});
    axi_wvalid = 1'b0;
    #1;
    checks++; if (axi_arready !== 1'b1) begin errors++; $display("FAIL collide_ar_next got=%b exp=1", axi_arready); end
    tick();
    model_q.push_back('{1'b1, ra, '0, '0});
    axi_arvalid = 1'b0;
    #1;
    checks++; if (req_count !== 5'd2 || axi_arready !== 1'b0) begin errors++; $display("FAIL collide_count count=%0d arready=%b exp=2/0", req_count, axi_arready); end
    tick();
    for (int i = 0; i < 2; i++) begin
      do_pop(got, ok);
      exp = (model_q.size() != 0) ? model_q.pop_front() : '0;
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL collide_order%0d ok=%b got=%h exp=%h", i, ok, got, exp); end
    end
    rd_exp = $urandom;
    do_rsp_read(rd_exp, rd_got, ok);
    checks++; if (!ok || rd_got !== rd_exp) begin errors++; $display("FAIL collide_rdata ok=%b got=%h exp=%h", ok, rd_got, rd_exp); end
  endtask

  task automatic test_random_mix();
    bit master_done;
    bit rsp_pending;
    int cyc;
    master_done = 1'b0;
    rsp_pending = 1'b0;
    cyc = 0;
    fork
      begin
        for (int n = 0; n < 10; n++) begin
          bit ok;
          bit got_r;
          logic [DW-1:0] rd;
          if ($urandom_range(0, 2) != 0) begin
            do_write(AW'($urandom), $urandom, SW'($urandom), ok);
            checks++; if (!ok) begin errors++; $display("FAIL mix_write%0d got=timeout exp=done", n); end
          end else begin
            do_ar(AW'($urandom), ok);
            checks++; if (!ok) begin errors++; $display("FAIL mix_ar%0d got=timeout exp=done", n); end
            axi_rready = 1'b1;
            got_r = 1'b0;
            rd = '0;
            for (int i = 0; i < 200 && ok && !got_r; i++) begin
              #1;
              if (axi_rvalid) begin
                got_r = 1'b1;
                rd = axi_rdata;
              end
              tick();
            end
            axi_rready = 1'b0;
            checks++; if (!got_r || rd !== exp_rdata) begin errors++; $display("FAIL mix_rdata%0d seen=%b got=%h exp=%h", n, got_r, rd, exp_rdata); end
          end
        end
        master_done = 1'b1;
      end
      begin
        while ((!master_done || model_q.size() != 0) && cyc < 3000) begin
          req_t exp;
          req_rdy = 1'($urandom_range(0, 1));
          if (rsp_pending) begin
            rsp_vld = 1'b1;
            rsp_data = $urandom;
            exp_rdata = rsp_data;
            rsp_pending = 1'b0;
          end else begin
            rsp_vld = 1'b0;
          end
          #1;
          checks++; if (req_count > 5'(DEPTH)) begin errors++; $display("FAIL mix_count_bound got=%0d exp<=%0d", req_count, DEPTH); end
          checks++; if (req_vld !== (model_q.size() != 0)) begin errors++; $display("FAIL mix_req_vld got=%b exp=%b", req_vld, model_q.size() != 0); end
          if (req_vld && req_rdy && model_q.size() != 0) begin
            exp = model_q.pop_front();
            checks++; if ({req_typ, req_addr, req_data, req_strb} !== exp) begin errors++; $display("FAIL mix_order got=%h exp=%h", {req_typ, req_addr, req_data, req_strb}, exp); end
            if (exp.typ) rsp_pending = 1'b1;
          end
          tick();
          cyc++;
        end
        req_rdy = 1'b0;
        rsp_vld = 1'b0;
      end
    join
    checks++; if (cyc >= 3000) begin errors++; $display("FAIL mix_timeout cycles=%0d exp<3000", cyc); end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    req_t exp;
    req_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_write(AW'($urandom), $urandom, SW'($urandom), ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_write%0d got=timeout exp=done", i); end
    end
    do_ar(AW'($urandom), ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_ar got=timeout exp=done"); end
    rsp_vld = 1'b1;
    rsp_data = $urandom;
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (req_count !== 5'd3 || axi_rvalid !== 1'b1) begin errors++; $display("FAIL midrst_setup count=%0d rvalid=%b exp=3/1", req_count, axi_rvalid); end
    tick();
    rstn = 1'b0;
    #1;
    checks++; if ({req_vld, axi_rvalid, axi_awready, axi_arready} !== 4'b0000 || req_count !== 5'd0) begin errors++; $display("FAIL midrst_flush vld/rvalid/aw/ar=%b count=%0d exp=0000/0", {req_vld, axi_rvalid, axi_awready, axi_arready}, req_count); end
    model_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    #1;
    checks++; if (axi_awready !== 1'b1 || axi_arready !== 1'b1) begin errors++; $display("FAIL midrst_release aw=%b ar=%b exp=1/1", axi_awready, axi_arready); end
    tick();
    req_rdy = 1'b1;
    do_write(AW'(16'h7FF0), 32'hA5A55A5A, 4'h3, ok);
    exp = '{1'b0, AW'(16'h7FF0), 32'hA5A55A5A, 4'h3};
    #1;
    checks++; if (!ok || {req_vld, req_typ, req_addr, req_data, req_strb} !== {1'b1, exp}) begin errors++; $display("FAIL midrst_next ok=%b got=%h exp=%h", ok, {req_vld, req_typ, req_addr, req_data, req_strb}, {1'b1, exp}); end
    if (model_q.size() != 0) void'(model_q.pop_front());
    tick();
    req_rdy = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_full();
    test_write_read_collision();
    test_random_mix();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
